// File: rtl/ins_step_sequencer_pkg.sv
// ============================================================================
// Module      : ins_step_sequencer_pkg
// Description : ISA constants (instruction IDs, InsM/cond codes) and
//               per-instruction step-length helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ins_step_sequencer_pkg;

    localparam int STEP_BITS = 3;
    localparam int ID_BITS   = 6;

    localparam logic [STEP_BITS-1:0] STEP_MAX = 3'd4;

    localparam logic [ID_BITS-1:0] ID_NONE  = 6'h00;
    localparam logic [ID_BITS-1:0] ID_LHI   = 6'h01;
    localparam logic [ID_BITS-1:0] ID_LLI   = 6'h02;
    localparam logic [ID_BITS-1:0] ID_LDRRI = 6'h03;
    localparam logic [ID_BITS-1:0] ID_LDRRR = 6'h04;
    localparam logic [ID_BITS-1:0] ID_STRRI = 6'h05;
    localparam logic [ID_BITS-1:0] ID_STRRR = 6'h06;
    localparam logic [ID_BITS-1:0] ID_ADD   = 6'h07;
    localparam logic [ID_BITS-1:0] ID_ADC   = 6'h08;
    localparam logic [ID_BITS-1:0] ID_SUB   = 6'h09;
    localparam logic [ID_BITS-1:0] ID_SBB   = 6'h0A;
    localparam logic [ID_BITS-1:0] ID_CMP   = 6'h0B;
    localparam logic [ID_BITS-1:0] ID_ADDI  = 6'h0C;
    localparam logic [ID_BITS-1:0] ID_SUBI  = 6'h0D;
    localparam logic [ID_BITS-1:0] ID_MOV   = 6'h0E;
    localparam logic [ID_BITS-1:0] ID_BCC   = 6'h0F;
    localparam logic [ID_BITS-1:0] ID_BCS   = 6'h10;
    localparam logic [ID_BITS-1:0] ID_BEQ   = 6'h11;
    localparam logic [ID_BITS-1:0] ID_BNE   = 6'h12;
    localparam logic [ID_BITS-1:0] ID_BAL   = 6'h13;
    localparam logic [ID_BITS-1:0] ID_JMP   = 6'h14;
    localparam logic [ID_BITS-1:0] ID_JALRL = 6'h15;
    localparam logic [ID_BITS-1:0] ID_JALRR = 6'h16;
    localparam logic [ID_BITS-1:0] ID_JR    = 6'h17;
    localparam logic [ID_BITS-1:0] ID_OUTR  = 6'h18;
    localparam logic [ID_BITS-1:0] ID_HLT   = 6'h19;

    localparam logic [4:0] M_ALU   = 5'b00000;
    localparam logic [4:0] M_LHI   = 5'b00001;
    localparam logic [4:0] M_LLI   = 5'b00010;
    localparam logic [4:0] M_LDRRI = 5'b00011;
    localparam logic [4:0] M_LDRRR = 5'b00100;
    localparam logic [4:0] M_STRRI = 5'b00101;
    localparam logic [4:0] M_STRRR = 5'b00110;
    localparam logic [4:0] M_ADDI  = 5'b00111;
    localparam logic [4:0] M_SUBI  = 5'b01000;
    localparam logic [4:0] M_MOV   = 5'b01011;
    localparam logic [4:0] M_BR    = 5'b11000;
    localparam logic [4:0] M_BAL   = 5'b11001;
    localparam logic [4:0] M_JMP   = 5'b10000;
    localparam logic [4:0] M_JALRL = 5'b10001;
    localparam logic [4:0] M_JALRR = 5'b10010;
    localparam logic [4:0] M_JR    = 5'b10011;
    localparam logic [4:0] M_SYS   = 5'b11100;

    localparam logic [2:0] COND_CC = 3'b011;
    localparam logic [2:0] COND_CS = 3'b010;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_AL = 3'b110;

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_HALTED = 1'b1
    } seq_state_e;

    // Final step of each instruction; 0 means "no normal completion" (illegal, HLT).
    function automatic logic [STEP_BITS-1:0] last_step(input logic [ID_BITS-1:0] id);
        case (id)
            ID_LHI, ID_LLI, ID_MOV, ID_JMP, ID_JR, ID_BCC, ID_BCS,
            ID_BEQ, ID_BNE, ID_BAL, ID_OUTR:                           last_step = 3'd2;
            ID_ADD, ID_ADC, ID_SUB, ID_SBB, ID_CMP, ID_ADDI, ID_SUBI,
            ID_JALRL, ID_JALRR, ID_STRRI, ID_STRRR:                    last_step = 3'd3;
            ID_LDRRI, ID_LDRRR:                                        last_step = 3'd4;
            default:                                                   last_step = 3'd0;
        endcase
    endfunction

    function automatic logic uses_alu(input logic [ID_BITS-1:0] id);
        case (id)
            ID_ADD, ID_ADC, ID_SUB, ID_SBB, ID_CMP, ID_ADDI, ID_SUBI,
            ID_LDRRI, ID_LDRRR, ID_STRRI, ID_STRRR: uses_alu = 1'b1;
            default:                                uses_alu = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ins_step_sequencer_decode.sv
// ============================================================================
// Module      : ins_step_sequencer_decode
// Description : Combinational instruction-word to instruction-ID decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_step_sequencer_decode
    import ins_step_sequencer_pkg::*;
(
    input  logic [15:0]        ins,
    output logic [ID_BITS-1:0] id,
    output logic               legal
);

    logic [4:0] w_insm;
    logic [2:0] w_cond;
    logic [1:0] w_insl;

    assign w_insm = ins[15:11];
    assign w_cond = ins[10:8];
    assign w_insl = ins[1:0];

    always_comb begin
        id = ID_NONE;
        case (w_insm)
            M_ALU: begin
                case (w_insl)
                    2'b00:   id = ID_ADD;
                    2'b01:   id = ID_ADC;
                    2'b10:   id = ID_SUB;
                    default: id = ID_SBB;
                endcase
            end
            M_LHI:   id = ID_LHI;
            M_LLI:   id = ID_LLI;
            M_LDRRI: id = ID_LDRRI;
            M_LDRRR: if (w_insl == 2'b00) id = ID_LDRRR;
            M_STRRI: id = ID_STRRI;
            M_STRRR: begin
                if (w_insl == 2'b00)      id = ID_STRRR;
                else if (w_insl == 2'b01) id = ID_CMP;
            end
            M_ADDI:  id = ID_ADDI;
            M_SUBI:  id = ID_SUBI;
            M_MOV:   id = ID_MOV;
            M_BR: begin
                case (w_cond)
                    COND_CC: id = ID_BCC;
                    COND_CS: id = ID_BCS;
                    COND_EQ: id = ID_BEQ;
                    COND_NE: id = ID_BNE;
                    default: id = ID_NONE;
                endcase
            end
            M_BAL:   if (w_cond == COND_AL) id = ID_BAL;
            M_JMP:   id = ID_JMP;
            M_JALRL: id = ID_JALRL;
            M_JALRR: id = ID_JALRR;
            M_JR:    id = ID_JR;
            M_SYS: begin
                if (w_insl == 2'b00)      id = ID_OUTR;
                else if (w_insl == 2'b01) id = ID_HLT;
            end
            default: id = ID_NONE;
        endcase
    end

    assign legal = (id != ID_NONE);

endmodule

`default_nettype wire

// File: rtl/ins_step_sequencer.sv
// ============================================================================
// Module      : ins_step_sequencer
// Description : Multicycle step sequencer: fetch/decode, step counter, halt
//               flag and step-qualified control strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_step_sequencer
    import ins_step_sequencer_pkg::*;
#(
    parameter int CNT_W = 3,
    parameter int ID_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    input  logic [15:0]      ins,
    input  logic             resume,
    output logic             ins_ready,
    output logic [ID_W-1:0]  ins_id,
    output logic [CNT_W-1:0] cnt,
    output logic             alu_or_not,
    output logic             buff_pc,
    output logic             illegal,
    output logic             halted
);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_id_nxt;

    logic [ID_W-1:0]  w_dec_id;
    logic             w_dec_legal;
    logic [CNT_W-1:0] w_last;
    logic             w_active;
    logic             w_step1;
    logic             w_illegal_step;
    logic             w_hlt_step;

    ins_step_sequencer_decode u_decode (
        .ins   (ins),
        .id    (w_dec_id),
        .legal (w_dec_legal)
    );

    assign w_last         = last_step(r_id);
    assign w_active       = (r_state == ST_ACTIVE);
    assign w_step1        = w_active && (r_cnt == CNT_W'(1));
    // A zero ID at step 1 can only come from a word that failed decode.
    assign w_illegal_step = w_step1 && (r_id == ID_NONE);
    assign w_hlt_step     = w_step1 && (r_id == ID_HLT);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_id_nxt    = r_id;
        case (r_state)
            ST_ACTIVE: begin
                if (r_cnt == '0) begin
                    if (ins_valid) begin
                        w_id_nxt  = w_dec_legal ? w_dec_id : ID_NONE;
                        w_cnt_nxt = CNT_W'(1);
                    end
                end else if (r_cnt > STEP_MAX) begin
                    w_cnt_nxt = '0;
                end else if (w_hlt_step) begin
                    w_state_nxt = ST_HALTED;
                end else if (r_cnt < w_last) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt > STEP_MAX) begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
        end
    end

    assign ins_ready  = w_active && (r_cnt == '0);
    assign ins_id     = r_id;
    assign cnt        = r_cnt;
    assign halted     = (r_state == ST_HALTED);
    assign illegal    = w_illegal_step;
    assign alu_or_not = w_active && (r_cnt == CNT_W'(2)) && uses_alu(r_id);
    assign buff_pc    = w_active && (r_cnt != '0) && (r_cnt <= STEP_MAX)
                        && ((r_cnt == w_last) || w_illegal_step);

endmodule

`default_nettype wire

// File: tb/tb_ins_step_sequencer.sv
// ============================================================================
// Module      : tb_ins_step_sequencer
// Description : Directed and random checks of ins_step_sequencer against a
//               table-driven ISA model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ins_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic [15:0] ins;
    logic        resume;
    logic        ins_ready;
    logic [5:0]  ins_id;
    logic [2:0]  cnt;
    logic        alu_or_not;
    logic        buff_pc;
    logic        illegal;
    logic        halted;

    int total = 0;
    int bad   = 0;

    ins_step_sequencer #(.CNT_W(3), .ID_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins        (ins),
        .resume     (resume),
        .ins_ready  (ins_ready),
        .ins_id     (ins_id),
        .cnt        (cnt),
        .alu_or_not (alu_or_not),
        .buff_pc    (buff_pc),
        .illegal    (illegal),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // One row per instruction: opcode fields (with don't-care flags), ID, length, ALU use.
    typedef struct {
        logic [4:0] m;
        logic [2:0] c;
        bit         c_care;
        logic [1:0] l;
        bit         l_care;
        logic [5:0] id;
        int         last;
        bit         alu;
    } op_t;

    op_t ops[25];

    task automatic set_op(input int i, input logic [4:0] m, input logic [2:0] c, input bit cc,
                          input logic [1:0] l, input bit lc, input int last, input bit alu);
        ops[i] = '{m, c, cc, l, lc, 6'(i + 1), last, alu};
    endtask

    function automatic int ref_decode(input logic [15:0] w);
        int r = -1;
        for (int i = 0; i < 25; i++)
            if (w[15:11] == ops[i].m && (!ops[i].c_care || w[10:8] == ops[i].c)
                && (!ops[i].l_care || w[1:0] == ops[i].l))
                r = i;
        return r;
    endfunction

    function automatic logic [15:0] encode(input int i);
        logic [15:0] w = 16'($urandom);
        w[15:11] = ops[i].m;
        if (ops[i].c_care) w[10:8] = ops[i].c;
        if (ops[i].l_care) w[1:0]  = ops[i].l;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one word at step 0 and follow it to completion (or through a halt/resume).
    task automatic run_word(input logic [15:0] w, input int halt_cycles);
        int idx = ref_decode(w);
        check("ready_before", 32'(ins_ready), 1);
        ins = w;
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        ins = 16'($urandom);
        if (idx < 0) begin
            check("ill_id", 32'(ins_id), 0);
            check("ill_cnt", 32'(cnt), 1);
            check("ill_pulse", 32'(illegal), 1);
            check("ill_buff", 32'(buff_pc), 1);
            tick();
            check("ill_cnt_back", 32'(cnt), 0);
            check("ill_pulse_end", 32'(illegal), 0);
        end else if (ops[idx].last == 0) begin
            check("hlt_id", 32'(ins_id), 32'(ops[idx].id));
            check("hlt_cnt1", 32'(cnt), 1);
            check("hlt_buff", 32'(buff_pc), 0);
            tick();
            check("hlt_halted", 32'(halted), 1);
            check("hlt_ready", 32'(ins_ready), 0);
            for (int k = 0; k < halt_cycles; k++) begin
                check("hlt_stuck", 32'(cnt), 1);
                check("hlt_nobuff", 32'(buff_pc), 0);
                tick();
            end
            resume = 1'b1;
            tick();
            resume = 1'b0;
            check("res_halted", 32'(halted), 0);
            check("res_cnt", 32'(cnt), 0);
        end else begin
            check("id", 32'(ins_id), 32'(ops[idx].id));
            for (int s = 1; s <= ops[idx].last; s++) begin
                check("step_cnt", 32'(cnt), 32'(s));
                check("step_alu", 32'(alu_or_not), 32'(s == 2 && ops[idx].alu));
                check("step_buff", 32'(buff_pc), 32'(s == ops[idx].last));
                check("step_illegal", 32'(illegal), 0);
                tick();
            end
            check("done_cnt", 32'(cnt), 0);
        end
        check("ready_after", 32'(ins_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_op(0,  5'b00001, 3'b000, 0, 2'b00, 0, 2, 0); // LHI
        set_op(1,  5'b00010, 3'b000, 0, 2'b00, 0, 2, 0); // LLI
        set_op(2,  5'b00011, 3'b000, 0, 2'b00, 0, 4, 1); // LDRri
        set_op(3,  5'b00100, 3'b000, 0, 2'b00, 1, 4, 1); // LDRrr
        set_op(4,  5'b00101, 3'b000, 0, 2'b00, 0, 3, 1); // STRri
        set_op(5,  5'b00110, 3'b000, 0, 2'b00, 1, 3, 1); // STRrr
        set_op(6,  5'b00000, 3'b000, 0, 2'b00, 1, 3, 1); // ADD
        set_op(7,  5'b00000, 3'b000, 0, 2'b01, 1, 3, 1); // ADC
        set_op(8,  5'b00000, 3'b000, 0, 2'b10, 1, 3, 1); // SUB
        set_op(9,  5'b00000, 3'b000, 0, 2'b11, 1, 3, 1); // SBB
        set_op(10, 5'b00110, 3'b000, 0, 2'b01, 1, 3, 1); // CMP
        set_op(11, 5'b00111, 3'b000, 0, 2'b00, 0, 3, 1); // ADDI
        set_op(12, 5'b01000, 3'b000, 0, 2'b00, 0, 3, 1); // SUBI
        set_op(13, 5'b01011, 3'b000, 0, 2'b00, 0, 2, 0); // MOV
        set_op(14, 5'b11000, 3'b011, 1, 2'b00, 0, 2, 0); // BCC
        set_op(15, 5'b11000, 3'b010, 1, 2'b00, 0, 2, 0); // BCS
        set_op(16, 5'b11000, 3'b001, 1, 2'b00, 0, 2, 0); // BEQ
        set_op(17, 5'b11000, 3'b000, 1, 2'b00, 0, 2, 0); // BNE
        set_op(18, 5'b11001, 3'b110, 1, 2'b00, 0, 2, 0); // BAL
        set_op(19, 5'b10000, 3'b000, 0, 2'b00, 0, 2, 0); // JMP
        set_op(20, 5'b10001, 3'b000, 0, 2'b00, 0, 3, 0); // JALrl
        set_op(21, 5'b10010, 3'b000, 0, 2'b00, 0, 3, 0); // JALrr
        set_op(22, 5'b10011, 3'b000, 0, 2'b00, 0, 2, 0); // JR
        set_op(23, 5'b11100, 3'b000, 0, 2'b00, 1, 2, 0); // OutR
        set_op(24, 5'b11100, 3'b000, 0, 2'b01, 1, 0, 0); // HLT

        rst = 1'b1; ins_valid = 1'b0; ins = 16'h0000; resume = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_cnt", 32'(cnt), 0);
        check("rst_id", 32'(ins_id), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_alu", 32'(alu_or_not), 0);
        check("rst_buff", 32'(buff_pc), 0);
        check("rst_ready", 32'(ins_ready), 1);

        run_word(16'h0000, 0);           // ADD
        check("add_id_hold", 32'(ins_id), 32'h07);
        run_word(16'h2000, 0);           // LDRrr
        run_word(16'hC300, 0);           // BCC
        check("bcc_id", 32'(ins_id), 32'h0F);
        run_word(16'hCE00, 0);           // BAL
        check("bal_id", 32'(ins_id), 32'h13);

        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_cnt", 32'(cnt), 0);
            check("stall_id", 32'(ins_id), 32'h13);
        end

        resume = 1'b1;
        tick();
        tick();
        resume = 1'b0;
        check("resume_idle_cnt", 32'(cnt), 0);
        check("resume_idle_ready", 32'(ins_ready), 1);

        run_word(16'hE001, 10);          // HLT
        check("hlt_id_after", 32'(ins_id), 32'h19);
        run_word(16'h4800, 0);           // illegal InsM 01001

        // Reset at step 3 of LDRri aborts the instruction.
        ins = 16'h1800; ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        tick();
        check("ldr_cnt3", 32'(cnt), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cnt", 32'(cnt), 0);
        check("abort_id", 32'(ins_id), 0);
        check("abort_buff", 32'(buff_pc), 0);
        check("abort_alu", 32'(alu_or_not), 0);
        check("abort_ready", 32'(ins_ready), 1);

        // rst and resume together while halted: reset wins.
        ins = 16'hE001; ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        check("halt2", 32'(halted), 1);
        rst = 1'b1; resume = 1'b1;
        tick();
        rst = 1'b0; resume = 1'b0;
        check("rstres_halted", 32'(halted), 0);
        check("rstres_id", 32'(ins_id), 0);
        check("rstres_cnt", 32'(cnt), 0);

        for (int i = 0; i < 25; i++)
            run_word(encode(i), 2);

        for (int k = 0; k < 40; k++)
            run_word(16'($urandom), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
